ysyx_23060332_ifu: RTL and testbench
====================================

// Module: ysyx_23060332_ifu
// PURPOSE
//  Instruction fetch unit; the producer for the decode stage. Owns the PC, issues word fetches on a
//  req/resp memory port, holds each returned instruction with its PC until decode accepts it
//  (valid/ready), then advances sequentially or to the EXU redirect target. One fetch in flight.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset; first fetch address
//  NOP_INST   32'h0000_0013  value on inst_o while no instruction is held (addi x0,x0,0)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  mem_req_valid   out  1   fetch request valid
//  mem_req_ready   in   1   memory accepts request this cycle
//  mem_req_addr    out  32  fetch address (= pc)
//  mem_resp_valid  in   1   response data valid (one-cycle pulse per accepted request)
//  mem_resp_data   in   32  fetched instruction word
//  inst_valid      out  1   inst_o/inst_addr_o hold a valid instruction for decode
//  inst_ready      in   1   decode consumes instruction this cycle
//  inst_o          out  32  instruction to decode
//  inst_addr_o     out  32  PC of inst_o
//  jump_en         in   1   redirect pulse from EXU (taken branch/jal/jalr)
//  jump_addr       in   32  redirect target
//  fetch_err       out  1   sticky misaligned-target flag (only driven with macro; else 0)
// BEHAVIOUR
//  - Reset (async assert, sync-free release): state=IDLE, pc=RESET_PC, drop=0, mem_req_valid=0,
//    inst_valid=0, inst_o=NOP_INST, inst_addr_o=RESET_PC, fetch_err=0.
//  - FSM states IDLE, REQ, WAIT, HOLD:
//    IDLE: one cycle after reset release -> REQ.
//    REQ : mem_req_valid=1, addr=pc. req_ready=1 -> WAIT. Else stay.
//    WAIT: on resp_valid: drop=1 -> clear drop, -> REQ (data discarded);
//          drop=0 -> inst_o<=resp_data, inst_addr_o<=pc, -> HOLD.
//    HOLD: inst_valid=1; inst_o/inst_addr_o stable. inst_ready=1 -> pc<=pc+4, -> REQ.
//  - Min latency: request accepted cycle N, resp cycle N+1, inst_valid cycle N+2.
//  - inst_valid/mem_req_valid are registered state decodes; no combinational in->out paths.
//  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  - Redirect (jump_en=1) has priority over all other updates, pc<=jump_addr:
//    REQ, req_ready=0: stay REQ, next request uses new pc.
//    REQ, req_ready=1: old-pc request accepted; -> WAIT with drop=1.
//    WAIT, no resp: drop<=1. WAIT, resp same cycle: data discarded, -> REQ, drop=0.
//    HOLD (inst_ready any value): held instruction discarded, inst_valid falls next cycle, -> REQ.
//    IDLE: pc<=jump_addr, -> REQ.
//  - inst_o returns to NOP_INST whenever leaving HOLD; inst_addr_o keeps last value.
//  - mem_resp_valid outside WAIT is ignored.
// CONFIGURATION
//  IFU_MISALIGN_CHECK_EN defined: jump_en with jump_addr[1:0]!=0 sets fetch_err=1 (sticky until
//    reset), FSM -> IDLE and stays (no further requests, inst_valid=0); in-flight resp ignored.
//  Not defined: jump_addr[1:0] forced to 2'b00; fetch_err tied 0.
// TESTING
//  1 Reset, ready=1, 1-cycle resp: requests 0x80000000,04,08; inst_valid first at 2nd cycle after
//    first accept; inst_addr_o tracks each.
//  2 inst_ready=0 for 5 cycles in HOLD: inst_o/inst_addr_o stable, no new mem request issued.
//  3 jump_en to 0x80000100 while WAIT: response dropped, next request 0x80000100, no inst_valid
//    for stale word.
//  4 jump_en in HOLD with inst_ready=1: held inst discarded, next request = jump_addr.
//  5 pc=32'hFFFF_FFFC consumed -> next request 0x00000000.
//  6 Macro on: jump_addr=0x80000102 -> fetch_err=1, mem_req_valid stays 0; macro off: fetch 0x80000100.
//  Also: rst_n asserted in WAIT mid-fetch -> all outputs to reset values immediately.

Source files
------------

// File: rtl/ysyx_23060332_ifu_if.sv
// IFU bus bundle: memory req/resp port, decode handshake, EXU redirect.
// master = fetch unit side, slave = memory/decode/EXU environment side.
interface ysyx_23060332_ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        fetch_err;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output inst_valid,
    output inst_o,
    output inst_addr_o,
    output fetch_err,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  inst_ready,
    input  jump_en,
    input  jump_addr
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  inst_valid,
    input  inst_o,
    input  inst_addr_o,
    input  fetch_err,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    output inst_ready,
    output jump_en,
    output jump_addr
  );
endinterface

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: PC owner, one fetch in flight, holds inst for decode.
// IFU_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetch_err and halts.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_23060332_ifu_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] inst_q;
  logic [31:0] inst_addr_q;
  logic        drop;
  logic        drop_n;
  logic        err;
  logic        err_n;
  logic        cap;
  logic [31:0] jaddr;
  logic        bad;

`ifdef IFU_MISALIGN_CHECK_EN
  always_comb begin
    jaddr = bus.jump_addr;
    bad   = bus.jump_en
          && (bus.jump_addr[1:0] != 2'b00);
  end
`else
  logic unused_low;
  assign unused_low = ^bus.jump_addr[1:0];
  always_comb begin
    jaddr = {bus.jump_addr[31:2], 2'b00};
    bad   = 1'b0;
  end
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    err_n   = err;
    cap     = 1'b0;
    if (bad) begin
      err_n   = 1'b1;
      state_n = IDLE;
      pc_n    = jaddr;
      drop_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!err) begin
            state_n = REQ;
            if (bus.jump_en) pc_n = jaddr;
          end
        end
        REQ: begin
          if (bus.jump_en) pc_n = jaddr;
          if (bus.mem_req_ready) begin
            state_n = WAIT;
            drop_n  = bus.jump_en;
          end
        end
        WAIT: begin
          if (bus.jump_en) pc_n = jaddr;
          if (bus.mem_resp_valid) begin
            drop_n = 1'b0;
            if (drop || bus.jump_en) begin
              state_n = REQ;
            end else begin
              state_n = HOLD;
              cap     = 1'b1;
            end
          end else if (bus.jump_en) begin
            drop_n = 1'b1;
          end
        end
        HOLD: begin
          if (bus.jump_en) begin
            state_n = REQ;
            pc_n    = jaddr;
          end else if (bus.inst_ready) begin
            state_n = REQ;
            pc_n    = pc + 32'd4;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      err         <= 1'b0;
      inst_q      <= NOP_INST;
      inst_addr_q <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
      err   <= err_n;
      if (cap) begin
        inst_q      <= bus.mem_resp_data;
        inst_addr_q <= pc;
      end
    end
  end

  // Outputs decode registered state only.
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_req_addr  = pc;
  assign bus.inst_valid    = (state == HOLD);
  assign bus.inst_o        = (state == HOLD)
                           ? inst_q : NOP_INST;
  assign bus.inst_addr_o   = inst_addr_q;
  assign bus.fetch_err     = err;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Bench for ysyx_23060332_ifu: transaction-level model plus directed pins.
// Honours IFU_MISALIGN_CHECK_EN for the misaligned-redirect scenario.
module tb_ysyx_23060332_ifu;
  localparam logic [31:0] RST = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060332_ifu_if bus();

  ysyx_23060332_ifu #(
    .RESET_PC(RST),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  // transaction model: next fetch pc, outstanding fetch, held inst
  logic [31:0] m_pc;
  logic [31:0] m_raddr;
  logic [31:0] m_rdata;
  logic [31:0] m_haddr;
  logic [31:0] m_hdata;
  logic        m_idle;
  logic        m_out;
  logic        m_stale;
  logic        m_hold;
  logic        m_dead;
  int          m_wait;
  int          lat_lo = 0;
  int          lat_hi = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  function automatic logic is_bad(input logic j,
                                  input logic [31:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
    return j && (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc    = RST;
    m_idle  = 1'b1;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_hold  = 1'b0;
    m_dead  = 1'b0;
    m_wait  = 0;
    m_raddr = '0;
    m_rdata = '0;
    m_haddr = RST;
    m_hdata = NOP;
  endtask

  task automatic compare();
    logic er;
    logic ev;
    er = !m_dead && !m_idle && !m_out && !m_hold;
    ev = m_hold && !m_dead;
    chk("req_valid", 32'(bus.mem_req_valid), 32'(er));
    if (er) chk("req_addr", bus.mem_req_addr, m_pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(ev));
    if (ev) begin
      chk("inst_o", bus.inst_o, m_hdata);
      chk("inst_addr", bus.inst_addr_o, m_haddr);
    end else begin
      chk("inst_nop", bus.inst_o, NOP);
    end
    chk("fetch_err", 32'(bus.fetch_err), 32'(m_dead));
  endtask

  task automatic step(input logic rdy,
                      input logic jen,
                      input logic [31:0] jad,
                      input logic irdy);
    logic er;
    logic acc;
    logic rsp;
    er = !m_dead && !m_idle && !m_out && !m_hold;
    compare();
    bus.mem_req_ready = rdy;
    bus.jump_en       = jen;
    bus.jump_addr     = jad;
    bus.inst_ready    = irdy;
    rsp = m_out && (m_wait == 0);
    bus.mem_resp_valid = rsp ||
      (!m_out && ($urandom_range(7, 0) == 0));
    bus.mem_resp_data = rsp ? m_rdata : $urandom;
    acc = er && rdy;
    if (m_dead) begin
    end else if (is_bad(jen, jad)) begin
      m_dead = 1'b1;
      m_out  = 1'b0;
      m_hold = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
      if (jen) m_pc = tgt(jad);
    end else if (acc) begin
      m_out   = 1'b1;
      m_stale = jen;
      m_raddr = m_pc;
      m_rdata = $urandom;
      m_wait  = int'($urandom_range(lat_hi, lat_lo));
      if (jen) m_pc = tgt(jad);
    end else if (m_out) begin
      if (rsp) begin
        m_out = 1'b0;
        if (!(m_stale || jen)) begin
          m_hold  = 1'b1;
          m_haddr = m_raddr;
          m_hdata = m_rdata;
        end
      end else begin
        m_wait--;
        if (jen) m_stale = 1'b1;
      end
      if (jen) m_pc = tgt(jad);
    end else if (m_hold) begin
      if (jen) begin
        m_hold = 1'b0;
        m_pc   = tgt(jad);
      end else if (irdy) begin
        m_hold = 1'b0;
        m_pc   = m_haddr + 32'd4;
      end
    end else if (jen) begin
      m_pc = tgt(jad);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.jump_en        = 1'b0;
    bus.jump_addr      = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pin_reset(input string tag);
    chk({tag, "_req"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, "_iv"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"}, bus.inst_o, 32'h0000_0013);
    chk({tag, "_iaddr"}, bus.inst_addr_o, 32'h8000_0000);
    chk({tag, "_err"}, 32'(bus.fetch_err), 32'd0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    pin_reset("rst");
    rst_n = 1'b1;

    // sequential fetch, one-cycle response
    step(1, 0, 0, 1);
    chk("t1_req0", bus.mem_req_addr, 32'h8000_0000);
    chk("t1_rv", 32'(bus.mem_req_valid), 32'd1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t1_iv", 32'(bus.inst_valid), 32'd1);
    chk("t1_ia0", bus.inst_addr_o, 32'h8000_0000);
    step(1, 0, 0, 1);
    chk("t1_req1", bus.mem_req_addr, 32'h8000_0004);
    repeat (3) step(1, 0, 0, 1);
    chk("t1_req2", bus.mem_req_addr, 32'h8000_0008);

    // decode stalls in HOLD
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    chk("t2_ia", bus.inst_addr_o, 32'h8000_0008);
    chk("t2_norq", 32'(bus.mem_req_valid), 32'd0);
    step(1, 0, 0, 1);

    // redirect while waiting for response
    lat_lo = 2;
    lat_hi = 2;
    step(1, 0, 0, 1);
    step(1, 1, 32'h8000_0100, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("t3_req", bus.mem_req_addr, 32'h8000_0100);
    chk("t3_iv", 32'(bus.inst_valid), 32'd0);
    lat_lo = 0;
    lat_hi = 0;

    // redirect while holding with decode ready
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 1, 32'h8000_0200, 1);
    chk("t4_req", bus.mem_req_addr, 32'h8000_0200);
    chk("t4_iv", 32'(bus.inst_valid), 32'd0);

    // pc wraps past top of address space
    step(0, 1, 32'hFFFF_FFFC, 1);
    chk("t5_req", bus.mem_req_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t5_ia", bus.inst_addr_o, 32'hFFFF_FFFC);
    step(1, 0, 0, 1);
    chk("t5_wrap", bus.mem_req_addr, 32'h0000_0000);

    // async reset in the middle of a fetch
    lat_lo = 2;
    lat_hi = 2;
    step(1, 0, 0, 1);
    compare();
    #2 rst_n = 1'b0;
    #1 pin_reset("arst");
    idle_inputs();
    model_reset();
    lat_lo = 0;
    lat_hi = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // misaligned redirect
    step(1, 0, 0, 1);
    step(0, 1, 32'h8000_0102, 1);
`ifdef IFU_MISALIGN_CHECK_EN
    repeat (3) step(1, 0, 0, 1);
    chk("t6_err", 32'(bus.fetch_err), 32'd1);
    chk("t6_norq", 32'(bus.mem_req_valid), 32'd0);
`else
    chk("t6_req", bus.mem_req_addr, 32'h8000_0100);
    chk("t6_err", 32'(bus.fetch_err), 32'd0);
`endif

    // randomized traffic
    do_reset();
    lat_lo = 0;
    lat_hi = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ja;
      ja = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
      ja[1:0] = 2'b00;
`endif
      step($urandom_range(3, 0) != 0,
           $urandom_range(9, 0) == 0,
           ja,
           $urandom_range(2, 0) != 0);
    end
    compare();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
